// File: rtl/fastclk_period_meter.sv
// Purpose: measures the interval, in i_clk cycles, between successive single-cycle event strobes.
// Latency: o_valid rises one cycle after the capturing i_event; o_data/o_sat held while o_valid=1.
// Backpressure: none upstream; a capture while a sample is unread overwrites it and sets o_overrun.
//
// Ports:
//   i_clk, i_rst      rising-edge clock, synchronous active-high reset
//   i_en              measurement enable; low returns to IDLE (pending sample kept)
//   i_event           single-cycle event strobe
//   o_data, o_sat     captured period and saturation flag (period >= 2^NBITS-1)
//   o_valid, i_ready  valid/ready output handshake
//   o_overrun         sticky overwrite flag, cleared by i_clr_overrun (set wins)
//   o_tstamp          only with FASTCLK_PERIOD_METER_TIMESTAMP_EN: free-running cycle count
//                     sampled on each capturing event
//
// The period counter is split into stages of at most NBITS_STAGE bits. Each stage keeps a
// registered "at all-ones" flag, so a stage only needs the AND of the lower flags to know it
// must increment; no ripple carry crosses a stage boundary.
module fastclk_period_meter #(
    parameter int NBITS       = 24,
    parameter int NBITS_STAGE = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_event,
    output logic [NBITS-1:0] o_data,
    output logic             o_sat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
`ifdef FASTCLK_PERIOD_METER_TIMESTAMP_EN
    output logic [NBITS-1:0] o_tstamp,
`endif
    input  logic             i_clr_overrun
);

    localparam int NSTAGES = (NBITS + NBITS_STAGE - 1) / NBITS_STAGE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMING  = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t             state;
    logic [NBITS-1:0]   cnt;
    logic [NSTAGES-1:0] stage_max;
    logic               cnt_sat;
    logic               cnt_clr;
    logic               cnt_load1;
    logic               cnt_inc;
    logic               capture;

    // The counter reads 2^NBITS-1 exactly when every stage is all-ones.
    assign cnt_sat = &stage_max;

    // A disabled meter does not capture, even if an event arrives in MEASURE.
    assign capture = i_en && i_event && (state == S_MEASURE);

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (!i_en || state == S_IDLE) begin
            cnt_clr = 1'b1;
        end else if (i_event) begin
            // Arming event or capture: the new period starts counting at 1.
            cnt_load1 = 1'b1;
        end else if (state == S_MEASURE && !cnt_sat) begin
            cnt_inc = 1'b1;
        end
    end

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
        localparam int LO = s * NBITS_STAGE;
        localparam int W  = ((NBITS - LO) < NBITS_STAGE) ? (NBITS - LO) : NBITS_STAGE;
        localparam logic [W-1:0] ONES = {W{1'b1}};

        logic [W-1:0] val;
        logic         at_max;
        logic         cin;

        if (s == 0) begin : g_c0
            assign cin = cnt_inc;
        end else begin : g_cn
            assign cin = cnt_inc & (&stage_max[s-1:0]);
        end

        always_ff @(posedge i_clk) begin
            if (i_rst || cnt_clr) begin
                val    <= '0;
                at_max <= 1'b0;
            end else if (cnt_load1) begin
                val    <= (s == 0) ? W'(1) : '0;
                at_max <= (s == 0) && (W == 1);
            end else if (cin) begin
                // Wraps to zero from all-ones; the next stage sees the same carry this cycle.
                val    <= val + W'(1);
                at_max <= (val == ONES - W'(1));
            end
        end

        assign cnt[LO +: W]  = val;
        assign stage_max[s]  = at_max;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            o_data    <= '0;
            o_sat     <= 1'b0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_en) state <= S_ARMING;
                end
                S_ARMING: begin
                    if (!i_en)        state <= S_IDLE;
                    else if (i_event) state <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (!i_en) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (capture) begin
                o_data  <= cnt;
                o_sat   <= cnt_sat;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            // A capture that lands on an unaccepted sample wins over a clear request.
            if (capture && o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                o_overrun <= 1'b0;
            end
        end
    end

`ifdef FASTCLK_PERIOD_METER_TIMESTAMP_EN
    logic [NBITS-1:0] ts;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ts       <= '0;
            o_tstamp <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (capture) o_tstamp <= ts;
        end
    end
`endif

endmodule

// File: tb/tb_fastclk_period_meter.sv
// Purpose: self-checking bench for fastclk_period_meter with a timestamp-based reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: i_ready driven per scenario (held, dropped, randomized).
module tb_fastclk_period_meter;

    localparam int NB   = 12;
    localparam int NS   = 4;
    localparam int MAXV = (1 << NB) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic          i_event;
    logic          i_ready;
    logic          i_clr_overrun;
    logic [NB-1:0] o_data;
    logic          o_sat;
    logic          o_valid;
    logic          o_overrun;
`ifdef FASTCLK_PERIOD_METER_TIMESTAMP_EN
    logic [NB-1:0] o_tstamp;
`endif

    always #5 i_clk = ~i_clk;

    fastclk_period_meter #(
        .NBITS       (NB),
        .NBITS_STAGE (NS)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_event       (i_event),
        .o_data        (o_data),
        .o_sat         (o_sat),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_overrun     (o_overrun),
`ifdef FASTCLK_PERIOD_METER_TIMESTAMP_EN
        .o_tstamp      (o_tstamp),
`endif
        .i_clr_overrun (i_clr_overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remembers the cycle number of the last accepted event and
    // derives each period by subtraction, clamped at 2^NB-1.
    int            cyc        = 0;
    bit            m_active   = 1'b0;  // enable was seen at the previous edge
    bit            m_have_ref = 1'b0;  // an arming event has been taken
    int            m_ref      = 0;
    bit            m_vld      = 1'b0;
    bit            m_sat      = 1'b0;
    bit            m_ovr      = 1'b0;
    logic [NB-1:0] m_data     = '0;

    // Drive one cycle of inputs, advance the model at the edge, settle 1 unit after it.
    task automatic tick(input bit rst, input bit en, input bit ev, input bit rdy, input bit clr);
        int gap;
        bit cap;
        bit setc;
        i_rst = rst; i_en = en; i_event = ev; i_ready = rdy; i_clr_overrun = clr;
        @(posedge i_clk);
        cyc++;
        cap = 1'b0;
        gap = 0;
        if (rst) begin
            m_active = 1'b0; m_have_ref = 1'b0;
            m_vld = 1'b0; m_sat = 1'b0; m_ovr = 1'b0; m_data = '0;
        end else begin
            if (!en) begin
                m_active   = 1'b0;
                m_have_ref = 1'b0;
            end else begin
                if (m_active && ev) begin
                    if (m_have_ref) begin
                        cap = 1'b1;
                        gap = cyc - m_ref;
                    end
                    m_have_ref = 1'b1;
                    m_ref      = cyc;
                end
                m_active = 1'b1;
            end
            setc = cap && m_vld && !rdy;
            if (cap) begin
                m_data = NB'((gap > MAXV) ? MAXV : gap);
                m_sat  = (gap >= MAXV);
                m_vld  = 1'b1;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
            if (setc)     m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0);
        checks++; if (o_data !== '0)     begin errors++; $display("FAIL reset_data got=%0d exp=0", o_data); end
        checks++; if (o_sat !== 1'b0)    begin errors++; $display("FAIL reset_sat got=%0b exp=0", o_sat); end
        checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", o_overrun); end
        tick(0, 0, 1, 0, 0);
        checks++;
        if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                     cyc, o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
        end
    endtask

    task automatic test_periodic();
        int nsamp = 0;
        for (int i = 0; i < 36; i++) begin
            tick(0, 1, (i % 10 == 1), 1, 0);
            checks++;
            if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
                errors++;
                $display("FAIL periodic cyc=%0d got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                         cyc, o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
            end
            if (o_valid === 1'b1) begin
                nsamp++;
                checks++;
                if (o_data !== NB'(10) || o_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL periodic_value got d=%0d s=%0b exp d=10 s=0", o_data, o_sat);
                end
            end
        end
        checks++;
        if (nsamp !== 3) begin errors++; $display("FAIL periodic_count got=%0d exp=3", nsamp); end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        tick(0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, 1, 0);
            checks++;
            if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
                errors++;
                $display("FAIL b2b cyc=%0d got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                         cyc, o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
            end
            if (i >= 1) begin
                checks++;
                if ({o_valid, o_data} !== {1'b1, NB'(1)}) begin
                    errors++;
                    $display("FAIL b2b_cont i=%0d got v=%0b d=%0d exp v=1 d=1", i, o_valid, o_data);
                end
            end
        end
        tick(0, 1, 0, 1, 0);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%0b exp v=0", o_valid); end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_stage_carries();
        int gaps[13] = '{15, 16, 17, 255, 256, 257, 511, 512, 513, 4094, 4095, 5000, 3};
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 1, 1, 0);
        foreach (gaps[k]) begin
            for (int j = 0; j < gaps[k]; j++) begin
                tick(0, 1, (j == gaps[k] - 1), 1, 0);
                checks++;
                if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
                    errors++;
                    $display("FAIL carry cyc=%0d gap=%0d got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                             cyc, gaps[k], o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
                end
            end
            checks++;
            if ({o_valid, o_sat, o_data} !== {1'b1, (gaps[k] >= MAXV), NB'((gaps[k] >= MAXV) ? MAXV : gaps[k])}) begin
                errors++;
                $display("FAIL carry_value gap=%0d got v=%0b s=%0b d=%0d", gaps[k], o_valid, o_sat, o_data);
            end
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        repeat (6) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b0, NB'(7)}) begin
            errors++; $display("FAIL ovr_first got v=%0b o=%0b d=%0d exp v=1 o=0 d=7", o_valid, o_overrun, o_data);
        end
        repeat (8) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b1, NB'(9)}) begin
            errors++; $display("FAIL ovr_second got v=%0b o=%0b d=%0d exp v=1 o=1 d=9", o_valid, o_overrun, o_data);
        end
        repeat (4) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 1);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b1, NB'(5)}) begin
            errors++; $display("FAIL ovr_set_wins got v=%0b o=%0b d=%0d exp v=1 o=1 d=5", o_valid, o_overrun, o_data);
        end
        tick(0, 1, 0, 0, 1);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b0, NB'(5)}) begin
            errors++; $display("FAIL ovr_clear got v=%0b o=%0b d=%0d exp v=1 o=0 d=5", o_valid, o_overrun, o_data);
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
            errors++;
            $display("FAIL ovr_drain got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                     o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
        end
    endtask

    task automatic test_accept_capture();
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        checks++;
        if ({o_valid, o_data} !== {1'b1, NB'(4)}) begin
            errors++; $display("FAIL acc_first got v=%0b d=%0d exp v=1 d=4", o_valid, o_data);
        end
        repeat (5) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 1, 0);
        checks++;
        if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b0, NB'(6)}) begin
            errors++; $display("FAIL acc_same_cycle got v=%0b o=%0b d=%0d exp v=1 o=0 d=6", o_valid, o_overrun, o_data);
        end
        tick(0, 1, 0, 1, 0);
        checks++;
        if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
            errors++;
            $display("FAIL acc_drain got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                     o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_rst_mid();
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        repeat (5) tick(0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        repeat (10) tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        checks++;
        if ({o_valid, o_overrun, o_sat, o_data} !== {1'b0, 1'b0, 1'b0, NB'(0)}) begin
            errors++; $display("FAIL rst_mid got v=%0b o=%0b s=%0b d=%0d exp all zero", o_valid, o_overrun, o_sat, o_data);
        end
        // Events while disabled, then on the cycle enable returns (still IDLE): all ignored.
        for (int i = 0; i < 4; i++) begin
            tick(0, (i == 3), 1, 1, 0);
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_event i=%0d got v=%0b exp v=0", i, o_valid); end
        end
        tick(0, 1, 1, 1, 0);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_arm_only got v=%0b exp v=0", o_valid); end
        repeat (7) tick(0, 1, 0, 1, 0);
        tick(0, 1, 1, 1, 0);
        checks++;
        if ({o_valid, o_sat, o_data} !== {1'b1, 1'b0, NB'(8)}) begin
            errors++; $display("FAIL rst_next_period got v=%0b s=%0b d=%0d exp v=1 s=0 d=8", o_valid, o_sat, o_data);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 79) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
            checks++;
            if ({o_valid, o_overrun, o_sat, o_data} !== {m_vld, m_ovr, m_sat, m_data}) begin
                errors++;
                $display("FAIL random cyc=%0d got v=%0b o=%0b s=%0b d=%0d exp v=%0b o=%0b s=%0b d=%0d",
                         cyc, o_valid, o_overrun, o_sat, o_data, m_vld, m_ovr, m_sat, m_data);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_event = 1'b0; i_ready = 1'b0; i_clr_overrun = 1'b0;
        test_reset();
        test_periodic();
        test_back_to_back();
        test_stage_carries();
        test_overrun();
        test_accept_capture();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
